// File: rtl/piton_credit_relay.sv
// -----------------------------------------------------------------------------
// piton_credit_relay
//
// Multi-channel credit-relay buffer for piton valid/yummy links. It sits
// between two routers (or a router and a piton-to-pronoc wrapper) and retimes
// long wires. Each channel has its own FIFO toward upstream and its own credit
// counter toward downstream. The channels never interact.
//
// Handshake (valid/yummy, credit based; there is no ready):
//   Upstream may assert in_valid only while it holds a credit. It starts with
//   DEPTH credits and gets one back for every in_yummy pulse.
//   This block asserts out_valid only while it holds a downstream credit, or
//   while a yummy arrives in the same cycle. It starts with DOWN_CREDITS
//   credits and gets one back for every out_yummy pulse.
//
// Parameters:
//   NCH          number of independent channels
//   DW           flit width per channel
//   DEPTH        FIFO entries per channel (power of two, >= 2)
//   DOWN_CREDITS initial and maximum credits toward downstream (1..15)
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   in_data/in_valid   upstream flits; channel c is in_data[c*DW +: DW]
//   in_yummy           one pulse per FIFO entry freed (credit back upstream)
//   out_data/out_valid registered downstream flits
//   out_yummy          credit return from downstream
//   overflow_err       sticky: a flit was dropped because the FIFO was full
//   credit_err         sticky: a yummy arrived while the counter was at max
//   flit_cnt/stall_cnt (PITON_CREDIT_RELAY_STATS_EN only) per-channel 32-bit
//                      counts of sends and of credit-starved cycles
//
// Debug visibility: credit_dbg[c] holds channel c's downstream credit counter.
// -----------------------------------------------------------------------------

module piton_credit_relay_ch #(
  parameter int DW           = 64,
  parameter int DEPTH        = 4,
  parameter int DOWN_CREDITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_yummy,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_yummy,
  output logic          overflow_err,
  output logic          credit_err,
  output logic [3:0]    credit_cnt
`ifdef PITON_CREDIT_RELAY_STATS_EN
  ,
  output logic [31:0]   flit_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [3:0] CMAX = 4'(DOWN_CREDITS);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic empty;
  logic full;
  logic send;
  logic push;

  assign empty = (count == '0);
  assign full  = (count == FULL);

  // A same-cycle yummy stands in for a missing credit, so the counter can
  // never underflow even when a send happens at zero credits.
  assign send = !empty && ((credit_cnt != 4'd0) || out_yummy);

  // When the FIFO is full, a push is accepted only if the head leaves in the
  // same cycle. Otherwise the flit is dropped.
  assign push = in_valid && (!full || send);

  // Storage is not reset. Reset only clears the pointers and the count, so
  // any flits still buffered are discarded.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      credit_cnt   <= CMAX;
      out_valid    <= 1'b0;
      out_data     <= '0;
      in_yummy     <= 1'b0;
      overflow_err <= 1'b0;
      credit_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (send) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_data <= mem[rd_ptr];
      end

      unique case ({push, send})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      // credit_next = credit - send + yummy. A yummy at max with no send is
      // ignored and flagged.
      if (send) begin
        credit_cnt <= credit_cnt - 4'd1 + {3'd0, out_yummy};
      end else if (out_yummy && (credit_cnt != CMAX)) begin
        credit_cnt <= credit_cnt + 4'd1;
      end

      out_valid <= send;
      // Each pop frees one entry, so it returns exactly one credit upstream.
      in_yummy  <= send;

      if (in_valid && !push) begin
        overflow_err <= 1'b1;
      end
      if (out_yummy && !send && (credit_cnt == CMAX)) begin
        credit_err <= 1'b1;
      end
    end
  end

`ifdef PITON_CREDIT_RELAY_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (send) begin
        flit_cnt <= flit_cnt + 32'd1;
      end
      // A cycle with data waiting but nothing sent means there was no credit.
      if (!empty && !send) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

module piton_credit_relay #(
  parameter int NCH          = 1,
  parameter int DW           = 64,
  parameter int DEPTH        = 4,
  parameter int DOWN_CREDITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_yummy,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_yummy,
  output logic [NCH-1:0]    overflow_err,
  output logic [NCH-1:0]    credit_err
`ifdef PITON_CREDIT_RELAY_STATS_EN
  ,
  output logic [NCH*32-1:0] flit_cnt,
  output logic [NCH*32-1:0] stall_cnt
`endif
);

  // Per-channel downstream credit counters, kept here for observation.
  logic [3:0] credit_dbg [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    piton_credit_relay_ch #(
      .DW           (DW),
      .DEPTH        (DEPTH),
      .DOWN_CREDITS (DOWN_CREDITS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data[c*DW +: DW]),
      .in_valid     (in_valid[c]),
      .in_yummy     (in_yummy[c]),
      .out_data     (out_data[c*DW +: DW]),
      .out_valid    (out_valid[c]),
      .out_yummy    (out_yummy[c]),
      .overflow_err (overflow_err[c]),
      .credit_err   (credit_err[c]),
      .credit_cnt   (credit_dbg[c])
`ifdef PITON_CREDIT_RELAY_STATS_EN
      ,
      .flit_cnt     (flit_cnt[c*32 +: 32]),
      .stall_cnt    (stall_cnt[c*32 +: 32])
`endif
    );
  end

endmodule

// File: tb/tb_piton_credit_relay.sv
// -----------------------------------------------------------------------------
// tb_piton_credit_relay
//
// Bench for piton_credit_relay with NCH=3, DW=16, DEPTH=4, DOWN_CREDITS=4.
// The reference model keeps, for each channel, a queue of buffered flits and
// an integer credit count. It applies the relay rules to those each cycle:
// send when there is a flit and a credit (or a same-cycle yummy), accept a
// push when there is room or the head leaves, and track both sticky errors.
// Every DUT output is compared 1 time unit after each rising edge.
// -----------------------------------------------------------------------------

module tb_piton_credit_relay;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int DEPTH = 4;
  localparam int DC  = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_yummy;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_yummy;
  logic [NCH-1:0]    overflow_err;
  logic [NCH-1:0]    credit_err;
`ifdef PITON_CREDIT_RELAY_STATS_EN
  logic [NCH*32-1:0] flit_cnt;
  logic [NCH*32-1:0] stall_cnt;
`endif

  piton_credit_relay #(
    .NCH          (NCH),
    .DW           (DW),
    .DEPTH        (DEPTH),
    .DOWN_CREDITS (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_yummy     (in_yummy),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_yummy    (out_yummy),
    .overflow_err (overflow_err),
    .credit_err   (credit_err)
`ifdef PITON_CREDIT_RELAY_STATS_EN
    ,
    .flit_cnt     (flit_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q [NCH][$];
  int            m_cred  [NCH];
  logic          m_ov    [NCH];
  logic          m_iy    [NCH];
  logic          m_oe    [NCH];
  logic          m_ce    [NCH];
  logic [DW-1:0] m_od    [NCH];
  logic [31:0]   m_flits [NCH];
  logic [31:0]   m_stall [NCH];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      m_cred[c]  = DC;
      m_ov[c]    = 1'b0;
      m_iy[c]    = 1'b0;
      m_oe[c]    = 1'b0;
      m_ce[c]    = 1'b0;
      m_od[c]    = '0;
      m_flits[c] = '0;
      m_stall[c] = '0;
    end
  endtask

  // Advance the model by one clock edge, given this cycle's inputs.
  task automatic model_cycle(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                             input logic [NCH-1:0] y);
    for (int c = 0; c < NCH; c++) begin
      int sz;
      bit snd;
      sz  = exp_q[c].size();
      snd = (sz > 0) && ((m_cred[c] > 0) || y[c]);
      if (snd) begin
        m_od[c] = exp_q[c].pop_front();
        m_ov[c] = 1'b1;
        m_iy[c] = 1'b1;
        m_flits[c] = m_flits[c] + 32'd1;
      end else begin
        m_ov[c] = 1'b0;
        m_iy[c] = 1'b0;
        if (sz > 0) m_stall[c] = m_stall[c] + 32'd1;
      end
      if (v[c]) begin
        if (sz < DEPTH || snd) exp_q[c].push_back(d[c*DW +: DW]);
        else m_oe[c] = 1'b1;
      end
      if (snd) m_cred[c] = m_cred[c] - 1 + int'(y[c]);
      else if (y[c]) begin
        if (m_cred[c] == DC) m_ce[c] = 1'b1;
        else m_cred[c] = m_cred[c] + 1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s out_valid[%0d]", ph, c), 64'(out_valid[c]), 64'(m_ov[c]));
      chk($sformatf("%s out_data[%0d]", ph, c), 64'(out_data[c*DW +: DW]), 64'(m_od[c]));
      chk($sformatf("%s in_yummy[%0d]", ph, c), 64'(in_yummy[c]), 64'(m_iy[c]));
      chk($sformatf("%s overflow_err[%0d]", ph, c), 64'(overflow_err[c]), 64'(m_oe[c]));
      chk($sformatf("%s credit_err[%0d]", ph, c), 64'(credit_err[c]), 64'(m_ce[c]));
      chk($sformatf("%s credit_cnt[%0d]", ph, c), 64'(dut.credit_dbg[c]), 64'(m_cred[c]));
`ifdef PITON_CREDIT_RELAY_STATS_EN
      chk($sformatf("%s flit_cnt[%0d]", ph, c), 64'(flit_cnt[c*32 +: 32]), 64'(m_flits[c]));
      chk($sformatf("%s stall_cnt[%0d]", ph, c), 64'(stall_cnt[c*32 +: 32]), 64'(m_stall[c]));
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string ph, input logic [NCH-1:0] v,
                      input logic [NCH*DW-1:0] d, input logic [NCH-1:0] y);
    in_valid  = v;
    in_data   = d;
    out_yummy = y;
    model_cycle(v, d, y);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, '0, '0, '0);
  endtask

  function automatic logic [NCH*DW-1:0] on_ch(input int c, input logic [DW-1:0] val);
    logic [NCH*DW-1:0] r;
    r = '0;
    r[c*DW +: DW] = val;
    return r;
  endfunction

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset(input string ph);
    in_valid  = '0;
    in_data   = '0;
    out_yummy = '0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(ph);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_yummy = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk) reset = 1'b1;

    // Single flit: visible two cycles after the push, with one in_yummy.
    step("single", 3'b001, on_ch(0, 16'hA5A5), 3'b000);
    idle("single", 4);

    // Credit starvation: 6 flits, 4 credits, then one yummy releases flit 5.
    do_reset("rst_starve");
    for (int i = 0; i < 6; i++) step("starve", 3'b001, on_ch(0, 16'h1000 + 16'(i)), 3'b000);
    idle("starve", 3);
    step("starve_y", 3'b000, '0, 3'b001);
    idle("starve", 3);

    // Overflow: 10 back-to-back flits with no credits returned.
    do_reset("rst_ovf");
    for (int i = 0; i < 10; i++) step("ovf", 3'b001, on_ch(0, 16'h2000 + 16'(i)), 3'b000);
    for (int i = 0; i < 6; i++) step("ovf_drain", 3'b000, '0, 3'b001);
    idle("ovf", 2);
    // Errors do not block traffic.
    step("ovf_after", 3'b001, on_ch(0, 16'h2BAD), 3'b000);
    idle("ovf_after", 3);

    // Credit error: a yummy with no traffic at full credits.
    do_reset("rst_cerr");
    step("cerr", 3'b000, '0, 3'b001);
    idle("cerr", 1);
    for (int i = 0; i < 3; i++) step("cerr_traffic", 3'b001, on_ch(0, 16'h3000 + 16'(i)), 3'b000);
    idle("cerr_traffic", 3);

    // Multi-channel: ch1 streams with yummies, ch2 starves, ch0 is idle.
    do_reset("rst_multi");
    for (int i = 0; i < 10; i++) begin
      logic [NCH*DW-1:0] d;
      d = on_ch(1, 16'h4000 + 16'(i)) | on_ch(2, 16'h5000 + 16'(i));
      step("multi", (i < 7) ? 3'b110 : 3'b010, d, (i > 0) ? 3'b010 : 3'b000);
    end
    idle("multi", 3);

    // Reset mid-stream with 3 flits buffered on ch0.
    do_reset("rst_mid_pre");
    for (int i = 0; i < 7; i++) step("mid", 3'b001, on_ch(0, 16'h6000 + 16'(i)), 3'b000);
    idle("mid", 1);
    do_reset("rst_mid");
    idle("mid_after", 4);

    // Random traffic on all channels.
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0]    v;
      logic [NCH-1:0]    y;
      logic [NCH*DW-1:0] d;
      for (int c = 0; c < NCH; c++) begin
        v[c] = ($urandom_range(0, 2) != 0);
        d[c*DW +: DW] = DW'($urandom);
        if (m_cred[c] < DC) y[c] = ($urandom_range(0, 2) != 0);
        else y[c] = ($urandom_range(0, 39) == 0);
      end
      step("rand", v, d, y);
    end
    idle("rand_tail", 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
